regfile_writeback_ctrl: RTL
===========================

Name: regfile_writeback_ctrl

Overview:
- Writeback-side driver of the 32x32 register file write port (WriteRegister/WriteData/RegWrite).
- Merges single-cycle ALU results with long-latency load results held in a small FIFO.
- Keeps a per-register pending scoreboard so decode can stall on read operands (ReadRegister1/2) whose load has not yet written back.
- Sits between the execute/LSU stages and the RegisterFile.

Parameters:
- DEPTH, 4, load-result FIFO entries (power of 2, >=2)
- STARVE_LIMIT, 3, consecutive cycles a non-empty FIFO may lose to the ALU before alu_stall asserts

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous reset, active-low
- alu_valid  in  1  ALU result present this cycle (no backpressure except alu_stall)
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- lsu_valid  in  1  load result offered
- lsu_ready  out  1  FIFO can accept (registered-state derived: count != DEPTH)
- lsu_rd  in  5  load destination register
- lsu_data  in  32  load data
- issue_valid  in  1  long-latency instruction issued this cycle
- issue_rd  in  5  its destination register
- ReadRegister1  in  5  decode operand 1 index
- ReadRegister2  in  5  decode operand 2 index
- hazard  out  1  combinational: pending[ReadRegister1] | pending[ReadRegister2]
- alu_stall  out  1  registered; upstream must hold ALU results while high
- WriteRegister  out  5  register-file write index (registered)
- WriteData  out  32  register-file write data (registered)
- RegWrite  out  1  register-file write enable (registered)
- fifo_count  out  log2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (clk edge with rst_n=0): RegWrite=0, WriteRegister=0, WriteData=0, alu_stall=0, FIFO emptied (fifo_count=0, lsu_ready=1), pending all 0, starve counter 0. Mid-operation reset discards FIFO contents and pending bits; no write is issued in the reset cycle.
- Push: lsu_valid & lsu_ready on an edge writes {lsu_rd, lsu_data} at the tail. When full, lsu_ready=0 even if a pop occurs the same cycle; no bypass.
- Select each cycle, by priority:
  - alu_stall=1 and FIFO non-empty: pop head.
  - Else alu_valid: take the ALU result.
  - Else FIFO non-empty: pop head.
  - Else idle.
- alu_valid while alu_stall=1 is a protocol violation. The result is dropped; no error output.
- Write: on the edge after select, WriteRegister/WriteData take the selected rd/data and RegWrite=1. Latency is exactly 1 cycle.
  - Selected rd=0: RegWrite=0. A pop still occurs and the entry is consumed.
  - Idle cycle: RegWrite=0; WriteRegister/WriteData hold their previous values.
- Starve counter:
  - Increments when FIFO non-empty and ALU wins.
  - Clears on any pop or when the FIFO is empty.
  - alu_stall is set on the edge where the counter reaches STARVE_LIMIT, and cleared on the edge that pops.
- Scoreboard: 32 pending bits, bit 0 hardwired 0.
  - issue_valid & issue_rd!=0 sets pending[issue_rd].
  - A pop of entry rd clears pending[rd].
  - Same-cycle set and clear of the same rd: set wins (newer instruction).
  - Push does not touch pending.
- hazard is purely combinational from current pending bits. It does not bypass the in-flight registered write.
- fifo_count: push-only +1, pop-only -1, push&pop unchanged. Pointers wrap modulo DEPTH.

Test Plan:
- Reset then alu_valid=1, alu_rd=5, alu_data=32'hABCDE123 -> next edge RegWrite=1, WriteRegister=5, WriteData=32'hABCDE123; fifo_count=0.
- issue_valid rd=7, then push lsu_rd=7 data=32'h1234_5678 with alu_valid=0 -> hazard=1 while ReadRegister1=7 until the pop edge; write of 7/32'h12345678 one cycle after the pop; hazard=0 thereafter.
- Push 4 loads (rd 1..4) while alu_valid stays 1 -> lsu_ready=0 at fifo_count=4; alu_stall=1 after 3 ALU wins; head rd=1 written next cycle; alu_stall drops after that pop.
- Push lsu_rd=0 data=32'hFFFF_FFFF -> entry popped, fifo_count decrements, RegWrite=0; alu_rd=0 also gives RegWrite=0.
- Same cycle: issue_valid rd=9 and pop of an entry with rd=9 -> pending[9]=1 afterwards, hazard=1 for ReadRegister2=9.
- Fill FIFO with 3 entries, set pending bits 3 and 4, assert rst_n=0 for one edge -> fifo_count=0, hazard=0 for all indices, RegWrite=0, lsu_ready=1.

Source files
------------

// File: rtl/regfile_writeback_ctrl.sv
// Register-file writeback controller: merges single-cycle ALU results with
// queued long-latency load results and tracks registers awaiting a load.

module regfile_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [4:0]    pushRd,
    input  logic [31:0]   pushData,
    output logic [4:0]    headRd,
    output logic [31:0]   headData,
    output logic [AW:0]   count
);
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wbEntry_t;

    localparam int CW = AW + 1;

    wbEntry_t [DEPTH-1:0] mem;
    logic [AW-1:0]        wrPtr;
    logic [AW-1:0]        rdPtr;

    assign headRd   = mem[rdPtr].rd;
    assign headData = mem[rdPtr].data;

    // Storage is not reset; only the pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= '{rd: pushRd, data: pushData};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + AW'(1);
            if (pop)  rdPtr <= rdPtr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module regfile_writeback_ctrl #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [31:0]              alu_data,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [4:0]               lsu_rd,
    input  logic [31:0]              lsu_data,
    input  logic                     issue_valid,
    input  logic [4:0]               issue_rd,
    input  logic [4:0]               ReadRegister1,
    input  logic [4:0]               ReadRegister2,
    output logic                     hazard,
    output logic                     alu_stall,
    output logic [4:0]               WriteRegister,
    output logic [31:0]              WriteData,
    output logic                     RegWrite,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic          fifoNonEmpty;
    logic          push;
    logic          pop;
    logic          aluTake;
    logic [4:0]    headRd;
    logic [31:0]   headData;
    logic [SW-1:0] starveCnt;
    logic [31:0]   pending;
    logic [31:0]   pendingNext;

    assign fifoNonEmpty = (fifo_count != '0);
    assign lsu_ready    = (fifo_count != (AW+1)'(DEPTH));
    assign push         = lsu_valid & lsu_ready;
    // A stalled ALU never wins: results offered during a stall are dropped.
    assign pop          = fifoNonEmpty & (alu_stall | ~alu_valid);
    assign aluTake      = alu_valid & ~alu_stall & ~pop;

    regfile_wb_fifo #(.DEPTH(DEPTH)) uFifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .pushRd   (lsu_rd),
        .pushData (lsu_data),
        .headRd   (headRd),
        .headData (headData),
        .count    (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else begin
            RegWrite <= 1'b0;
            if (pop) begin
                WriteRegister <= headRd;
                WriteData     <= headData;
                RegWrite      <= (headRd != 5'd0);
            end else if (aluTake) begin
                WriteRegister <= alu_rd;
                WriteData     <= alu_data;
                RegWrite      <= (alu_rd != 5'd0);
            end
        end
    end

    // Once the stall is raised the ALU cannot win, so the counter never passes the limit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starveCnt <= '0;
            alu_stall <= 1'b0;
        end else begin
            if (pop || !fifoNonEmpty) starveCnt <= '0;
            else if (aluTake)         starveCnt <= starveCnt + SW'(1);

            if (pop)
                alu_stall <= 1'b0;
            else if (fifoNonEmpty && aluTake && starveCnt == SW'(STARVE_LIMIT - 1))
                alu_stall <= 1'b1;
        end
    end

    // Issue is applied after the pop clear so a newer instruction keeps its bit.
    always_comb begin
        pendingNext = pending;
        if (pop)         pendingNext[headRd]   = 1'b0;
        if (issue_valid) pendingNext[issue_rd] = 1'b1;
        pendingNext[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) pending <= '0;
        else        pending <= pendingNext;
    end

    assign hazard = pending[ReadRegister1] | pending[ReadRegister2];
endmodule
